// File: rtl/fsm_scheduler.sv
// Two-requester round-robin scheduler driving the datapath's 2-bit control state machine.
// Latency: grant one edge after a request is sampled; state shows the first beat one edge later.
// Backpressure: requests are held until granted; op=1 blocks arbitration at its final edge.
module fsm_scheduler #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             select,
    output logic             op,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DONE1 = 2'b01,
        ST_RUN0  = 2'b10,
        ST_RUN1  = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_op_q;
    logic             r_owner;
    logic             r_ptr;      // last owner; the other requester wins a tie
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done;
    logic             r_done_id;
    logic [LEN_W-1:0] r_cnt;

    state_t           w_next_state;
    logic             w_cnt_zero;
    logic             w_arb_en;
    logic             w_grant;
    logic             w_win;
    logic             w_win_op;
    logic [LEN_W-1:0] w_win_len;
    logic             w_in_run1;

    // Next-state equation for the datapath state machine plus arbitration decode
    always_comb begin
        w_in_run1    = 1'b0;
        w_next_state = ST_IDLE;
        w_cnt_zero   = 1'b0;
        w_arb_en     = 1'b0;
        w_grant      = 1'b0;
        w_win        = 1'b0;
        w_win_op     = 1'b0;
        w_win_len    = '0;

        w_in_run1    = (r_state == ST_RUN1);
        // RUN1 always falls to DONE1; otherwise select/op pick the next beat type
        w_next_state = state_t'({r_busy & ~w_in_run1, w_in_run1 | (r_busy & r_op_q)});

        w_cnt_zero   = (r_cnt == '0);
        // A single-beat op=1 holds off arbitration at its last edge so RUN1 sees select=0
        w_arb_en     = (~r_busy | w_cnt_zero) & ~(r_busy & r_op_q);
        w_grant      = w_arb_en & (req0 | req1);

        if (req0 && req1) begin
            w_win = ~r_ptr;
        end else begin
            w_win = req1;
        end
        w_win_op  = w_win ? op1  : op0;
        w_win_len = w_win ? len1 : len0;
    end

    // Control registers: state, burst counter, ownership, grant and completion pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_op_q    <= 1'b0;
            r_owner   <= 1'b0;
            r_ptr     <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;

            // Last beat completes even when a new grant lands on the same edge
            if (r_busy && w_cnt_zero) begin
                r_done    <= 1'b1;
                r_done_id <= r_owner;
            end

            if (r_busy && !w_cnt_zero) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end

            if (w_grant) begin
                r_busy  <= 1'b1;
                r_op_q  <= w_win_op;
                r_cnt   <= w_win_op ? '0 : w_win_len;
                r_owner <= w_win;
                r_ptr   <= w_win;
                r_gnt0  <= ~w_win;
                r_gnt1  <= w_win;
            end else if (r_busy && w_cnt_zero) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign select  = r_busy;
    assign op      = r_op_q;
    assign busy    = r_busy;
    assign state   = r_state;
    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule

// File: tb/tb_fsm_scheduler.sv
// Directed bench for fsm_scheduler: reset, single bursts, contention, op1 streaming, mixed, async reset.
// Outputs are sampled 1 time unit after each rising edge.
// Inputs are changed only between edges, away from the sampling point.
module tb_fsm_scheduler;

    logic       clk;
    logic       reset;
    logic       req0, req1, op0, op1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, select, op, busy, done, done_id;
    logic [1:0] state;

    int total  = 0;
    int passed = 0;

    fsm_scheduler #(.LEN_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .op0     (op0),
        .op1     (op1),
        .len0    (len0),
        .len1    (len1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .select  (select),
        .op      (op),
        .state   (state),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"},   8'(state),   8'h0);
        chk({tag, ".busy"},    8'(busy),    8'h0);
        chk({tag, ".select"},  8'(select),  8'h0);
        chk({tag, ".op"},      8'(op),      8'h0);
        chk({tag, ".gnt0"},    8'(gnt0),    8'h0);
        chk({tag, ".gnt1"},    8'(gnt1),    8'h0);
        chk({tag, ".done"},    8'(done),    8'h0);
        chk({tag, ".done_id"}, 8'(done_id), 8'h0);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        len0 = 4'd0; len1 = 4'd0;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;

        // Single op0 burst, len=3
        req0 = 1'b1; op0 = 1'b0; len0 = 4'd3;
        step;
        chk("b0.gnt0", 8'(gnt0), 8'h1);
        chk("b0.gnt1", 8'(gnt1), 8'h0);
        chk("b0.select", 8'(select), 8'h1);
        chk("b0.state", 8'(state), 8'h0);
        req0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step;
            chk("b0.mid_gnt0", 8'(gnt0), 8'h0);
            chk("b0.mid_select", 8'(select), 8'h1);
            chk("b0.mid_state", 8'(state), 8'h2);
            chk("b0.mid_done", 8'(done), 8'h0);
        end
        step;
        chk("b0.last_state", 8'(state), 8'h2);
        chk("b0.last_select", 8'(select), 8'h0);
        chk("b0.done", 8'(done), 8'h1);
        chk("b0.done_id", 8'(done_id), 8'h0);
        step;
        chk("b0.idle_state", 8'(state), 8'h0);
        chk("b0.done_clr", 8'(done), 8'h0);

        // Single op1 on requester 1, len ignored
        req1 = 1'b1; op1 = 1'b1; len1 = 4'd7;
        step;
        chk("s1.gnt1", 8'(gnt1), 8'h1);
        chk("s1.select", 8'(select), 8'h1);
        chk("s1.op", 8'(op), 8'h1);
        req1 = 1'b0;
        step;
        chk("s1.run1_state", 8'(state), 8'h3);
        chk("s1.run1_select", 8'(select), 8'h0);
        chk("s1.done", 8'(done), 8'h1);
        chk("s1.done_id", 8'(done_id), 8'h1);
        step;
        chk("s1.done1_state", 8'(state), 8'h1);
        chk("s1.done_clr", 8'(done), 8'h0);
        step;
        chk("s1.idle_state", 8'(state), 8'h0);

        // Contention: both held, op=0, len=0; last owner was 1 so 0 wins first
        req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b0; len0 = 4'd0; len1 = 4'd0;
        for (int k = 0; k < 4; k++) begin
            step;
            chk("rr.gnt0", 8'(gnt0), 8'((k % 2) == 0));
            chk("rr.gnt1", 8'(gnt1), 8'((k % 2) == 1));
            chk("rr.select", 8'(select), 8'h1);
            if (k > 0) begin
                chk("rr.state", 8'(state), 8'h2);
                chk("rr.done", 8'(done), 8'h1);
                chk("rr.done_id", 8'(done_id), 8'((k - 1) % 2));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step;
        chk("rr.tail_select", 8'(select), 8'h0);
        chk("rr.tail_done_id", 8'(done_id), 8'h1);
        chk("rr.tail_state", 8'(state), 8'h2);
        step;
        chk("rr.idle_state", 8'(state), 8'h0);

        // op1 back-to-back on requester 0
        req0 = 1'b1; op0 = 1'b1;
        step;
        chk("bb.gnt0_first", 8'(gnt0), 8'h1);
        for (int k = 0; k < 3; k++) begin
            step;
            chk("bb.run1_gnt0", 8'(gnt0), 8'h0);
            chk("bb.run1_state", 8'(state), 8'h3);
            chk("bb.run1_select", 8'(select), 8'h0);
            step;
            chk("bb.done1_gnt0", 8'(gnt0), 8'h1);
            chk("bb.done1_state", 8'(state), 8'h1);
            chk("bb.done1_select", 8'(select), 8'h1);
        end
        req0 = 1'b0;
        step;
        chk("bb.tail_run1", 8'(state), 8'h3);
        step;
        chk("bb.tail_done1", 8'(state), 8'h1);
        chk("bb.tail_select", 8'(select), 8'h0);
        step;
        chk("bb.idle_state", 8'(state), 8'h0);

        // Mixed: op1 on requester 1, then op0 len=2 on requester 0 pending
        req1 = 1'b1; op1 = 1'b1;
        step;
        chk("mx.gnt1", 8'(gnt1), 8'h1);
        req1 = 1'b0;
        req0 = 1'b1; op0 = 1'b0; len0 = 4'd2;
        step;
        chk("mx.blocked_gnt0", 8'(gnt0), 8'h0);
        chk("mx.run1_state", 8'(state), 8'h3);
        step;
        chk("mx.gnt0", 8'(gnt0), 8'h1);
        chk("mx.done1_state", 8'(state), 8'h1);
        req0 = 1'b0;
        step;
        chk("mx.direct_run0", 8'(state), 8'h2);
        chk("mx.select", 8'(select), 8'h1);
        step;
        chk("mx.run0_b", 8'(state), 8'h2);
        step;
        chk("mx.run0_c", 8'(state), 8'h2);
        chk("mx.done", 8'(done), 8'h1);
        chk("mx.done_id", 8'(done_id), 8'h0);
        step;
        chk("mx.idle_state", 8'(state), 8'h0);

        // Async reset mid-burst; both then request, reset pointer must favour 0
        req0 = 1'b1; op0 = 1'b0; len0 = 4'd5;
        step;
        chk("ar.gnt0", 8'(gnt0), 8'h1);
        req0 = 1'b1;
        step;
        step;
        chk("ar.pre_busy", 8'(busy), 8'h1);
        chk("ar.pre_state", 8'(state), 8'h2);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("ar");
        req1 = 1'b1; op1 = 1'b0; len1 = 4'd1;
        #2;
        reset = 1'b0;
        step;
        chk("ar.regrant_gnt0", 8'(gnt0), 8'h1);
        chk("ar.regrant_gnt1", 8'(gnt1), 8'h0);
        chk("ar.regrant_select", 8'(select), 8'h1);
        req0 = 1'b0; req1 = 1'b0;
        step;
        chk("ar.state", 8'(state), 8'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
